// File: rtl/block_memory_pkg.sv
// Shared definitions for the block main memory: bus widths, port sequencer state encodings,
// and the word-address to block-index mapping.
package block_memory_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int FETCH_SIZE = 64;
    localparam int ADDR_W     = 16;

    localparam logic [1:0] MP_IDLE  = 2'd0;
    localparam logic [1:0] MP_RBUSY = 2'd1;
    localparam logic [1:0] MP_WBUSY = 2'd2;
    localparam logic [1:0] MP_RDONE = 2'd3;

    typedef logic [FETCH_SIZE-1:0] block_t;

    // A block holds four words, so the low two address bits select a word within it.
    function automatic logic [13:0] word_block(input logic [ADDR_W-1:0] addr);
        return addr[15:2];
    endfunction

endpackage

// File: rtl/block_memory_port_seq.sv
// One memory port: accepts a block read or write, counts fixed latency, and drives the bus
// with the loaded block from completion until the next acceptance.
module memory_port_seq
    import block_memory_pkg::*;
#(
    parameter int READ_LAT  = 3,
    parameter int WRITE_LAT = 4,
    parameter int IDX_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  read_m,
    input  logic                  write_m,
    input  logic [ADDR_W-1:0]     address_m,
    inout  wire  [FETCH_SIZE-1:0] data_m,
    input  block_t                rd_blk,
    output logic                  rd_load,
    output logic                  wr_commit,
    output logic [IDX_W-1:0]      idx,
    output block_t                wr_dat
);

    localparam logic [2:0] RD_LAT = 3'(READ_LAT);
    localparam logic [2:0] WR_LAT = 3'(WRITE_LAT);

    logic [1:0]       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d, cnt_nxt;
    logic [IDX_W-1:0] idx_q, idx_d, addr_idx;
    block_t           rdata_q, rdata_d;

    assign addr_idx = IDX_W'(word_block(address_m));
    assign cnt_nxt  = cnt_q + 3'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        idx       = idx_q;
        rd_load   = 1'b0;
        wr_commit = 1'b0;
        case (state_q)
            MP_RBUSY: begin
                cnt_d = cnt_nxt;
                if (cnt_nxt == RD_LAT) begin
                    rd_load = 1'b1;
                    state_d = MP_RDONE;
                end
            end
            MP_WBUSY: begin
                cnt_d = cnt_nxt;
                if (cnt_nxt == WR_LAT) begin
                    wr_commit = 1'b1;
                    state_d   = MP_IDLE;
                end
            end
            default: begin
                // Write wins when both requests are raised together.
                if (read_m || write_m) begin
                    idx   = addr_idx;
                    idx_d = addr_idx;
                    cnt_d = 3'd1;
                    if (write_m) begin
                        wr_commit = (WR_LAT == 3'd1);
                        state_d   = (WR_LAT == 3'd1) ? MP_IDLE : MP_WBUSY;
                    end else begin
                        rd_load = (RD_LAT == 3'd1);
                        state_d = (RD_LAT == 3'd1) ? MP_RDONE : MP_RBUSY;
                    end
                end
            end
        endcase
        rdata_d = rd_load ? rd_blk : rdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MP_IDLE;
            cnt_q   <= 3'd0;
            idx_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
        end
    end

    assign data_m = (state_q == MP_RDONE) ? rdata_q : {FETCH_SIZE{1'bz}};
    assign wr_dat = data_m;

endmodule

// File: rtl/block_memory.sv
// Dual-port fixed-latency block memory: two port sequencers over one unified array.
// Same-edge writes to one block resolve in favour of the D-port.
module block_memory
    import block_memory_pkg::*;
#(
    parameter int MEM_BLOCKS = 256,
    parameter int READ_LAT   = 3,
    parameter int WRITE_LAT  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_readM,
    input  logic                  i_writeM,
    input  logic [ADDR_W-1:0]     i_addressM,
    inout  wire  [FETCH_SIZE-1:0] i_dataM,
    input  logic                  d_readM,
    input  logic                  d_writeM,
    input  logic [ADDR_W-1:0]     d_addressM,
    inout  wire  [FETCH_SIZE-1:0] d_dataM
);

    localparam int IDX_W = (MEM_BLOCKS > 1) ? $clog2(MEM_BLOCKS) : 1;

    if ((MEM_BLOCKS < 2) || (MEM_BLOCKS > 16384) || ((MEM_BLOCKS & (MEM_BLOCKS - 1)) != 0)) begin : g_bad_blocks
        $error("MEM_BLOCKS must be a power of two between 2 and 16384");
    end
    if ((READ_LAT < 1) || (READ_LAT > 7) || (WRITE_LAT < 1) || (WRITE_LAT > 7)) begin : g_bad_lat
        $error("READ_LAT and WRITE_LAT must lie in 1..7");
    end

    block_t           mem_q [MEM_BLOCKS];
    logic             i_rd_load, i_wr_commit, d_rd_load, d_wr_commit;
    logic [IDX_W-1:0] i_idx, d_idx;
    block_t           i_rd_blk, d_rd_blk, i_wr_dat, d_wr_dat;

    // Reads see the array before this edge's writes, so a reader racing a writer gets old data.
    assign i_rd_blk = mem_q[i_idx];
    assign d_rd_blk = mem_q[d_idx];

    memory_port_seq #(.READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT), .IDX_W(IDX_W)) u_i_port (
        .clk       (clk),
        .reset_n   (reset_n),
        .read_m    (i_readM),
        .write_m   (i_writeM),
        .address_m (i_addressM),
        .data_m    (i_dataM),
        .rd_blk    (i_rd_blk),
        .rd_load   (i_rd_load),
        .wr_commit (i_wr_commit),
        .idx       (i_idx),
        .wr_dat    (i_wr_dat)
    );

    memory_port_seq #(.READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT), .IDX_W(IDX_W)) u_d_port (
        .clk       (clk),
        .reset_n   (reset_n),
        .read_m    (d_readM),
        .write_m   (d_writeM),
        .address_m (d_addressM),
        .data_m    (d_dataM),
        .rd_blk    (d_rd_blk),
        .rd_load   (d_rd_load),
        .wr_commit (d_wr_commit),
        .idx       (d_idx),
        .wr_dat    (d_wr_dat)
    );

    // Storage is deliberately not reset; the D-port write is ordered last so it wins a tie.
    always_ff @(posedge clk) begin
        if (i_wr_commit) mem_q[i_idx] <= i_wr_dat;
        if (d_wr_commit) mem_q[d_idx] <= d_wr_dat;
    end

endmodule

// File: tb/tb_block_memory.sv
// Bench for block_memory: vector table plus hand-written race and reset sequences.
module tb_block_memory;

    localparam logic [63:0] PROBE = 64'hC000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_readM, i_writeM, d_readM, d_writeM;
    logic [15:0] i_addressM, d_addressM;
    logic        i_drv_en, d_drv_en;
    logic [63:0] i_drv, d_drv;
    wire  [63:0] i_dataM, d_dataM;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    assign i_dataM = i_drv_en ? i_drv : 64'bz;
    assign d_dataM = d_drv_en ? d_drv : 64'bz;

    always #5 clk = ~clk;

    block_memory dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_readM    (i_readM),
        .i_writeM   (i_writeM),
        .i_addressM (i_addressM),
        .i_dataM    (i_dataM),
        .d_readM    (d_readM),
        .d_writeM   (d_writeM),
        .d_addressM (d_addressM),
        .d_dataM    (d_dataM)
    );

    typedef struct {
        bit          port;   // 0 = I, 1 = D
        bit          is_wr;
        logic [15:0] addr;
        logic [63:0] data;   // write data, or expected read data
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit p, input logic rd, input logic wr, input logic [15:0] a);
        if (p) begin d_readM = rd; d_writeM = wr; d_addressM = a; end
        else   begin i_readM = rd; i_writeM = wr; i_addressM = a; end
    endtask

    task automatic set_drv(input bit p, input logic en, input logic [63:0] v);
        if (p) begin d_drv_en = en; d_drv = v; end
        else   begin i_drv_en = en; i_drv = v; end
    endtask

    function automatic logic [63:0] get_bus(input bit p);
        return p ? d_dataM : i_dataM;
    endfunction

    // One-edge read request; bus must stay released until the third edge, then hold the block.
    task automatic do_read(input bit p, input logic [15:0] a, input logic [63:0] e);
        set_req(p, 1'b1, 1'b0, a);
        exp_q.push_back(e);
        tick();
        set_req(p, 1'b0, 1'b0, 16'h3FF0);
        set_drv(p, 1'b1, PROBE);
        @(negedge clk); check("rd_busy1_released", get_bus(p), PROBE);
        tick();
        @(negedge clk); check("rd_busy2_released", get_bus(p), PROBE);
        tick();
        set_drv(p, 1'b0, 64'h0);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_scoreboard_empty t=%0t", $time);
        end else begin
            check("rd_data", get_bus(p), exp_q.pop_front());
        end
        tick();
        @(negedge clk); check("rd_hold", get_bus(p), e);
    endtask

    // Cache-style write: request for three edges, data on the bus with request low for the fourth.
    task automatic do_write(input bit p, input logic [15:0] a, input logic [63:0] v, input logic rd_too);
        set_req(p, rd_too, 1'b1, a);
        tick();
        set_drv(p, 1'b1, PROBE);
        @(negedge clk); check("wr_busy1_released", get_bus(p), PROBE);
        tick();
        @(negedge clk); check("wr_busy2_released", get_bus(p), PROBE);
        tick();
        set_req(p, 1'b0, 1'b0, 16'h3FF0);
        set_drv(p, 1'b1, v);
        @(negedge clk); check("wr_busy3_released", get_bus(p), v);
        tick();
        set_drv(p, 1'b0, 64'h0);
    endtask

    localparam logic [63:0] V5  = 64'h0004_0003_0002_0001;
    localparam logic [63:0] VA  = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] V2  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] V7  = 64'h7777_0000_0000_0007;
    localparam logic [63:0] N7  = 64'h0707_0707_0707_0707;
    localparam logic [63:0] VB  = 64'hBBBB_0C0C_1234_5678;
    localparam logic [63:0] I9  = 64'h1919_1919_1919_1919;
    localparam logic [63:0] D9  = 64'hD9D9_D9D9_D9D9_D9D9;
    localparam logic [63:0] VF  = 64'h0FFF_0EEE_0DDD_0CCC;
    localparam logic [63:0] BAD = 64'h0BAD_0BAD_0BAD_0BAD;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b1, 1'b1, 16'h0014, V5};   // preload block 5
        vecs[1] = '{1'b1, 1'b0, 16'h0014, V5};
        vecs[2] = '{1'b1, 1'b1, 16'h0028, VA};   // block 10
        vecs[3] = '{1'b1, 1'b0, 16'h002B, VA};   // low address bits ignored
        vecs[4] = '{1'b0, 1'b1, 16'h0008, V2};   // block 2 via I-port
        vecs[5] = '{1'b0, 1'b0, 16'h000A, V2};
        vecs[6] = '{1'b0, 1'b0, 16'h0028, VA};   // unified array across ports
        vecs[7] = '{1'b1, 1'b1, 16'h041C, V7};   // block 263 wraps to 7
        vecs[8] = '{1'b0, 1'b0, 16'h001C, V7};

        reset_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 16'h0);
        set_req(1'b1, 1'b0, 1'b0, 16'h0);
        set_drv(1'b0, 1'b1, PROBE);
        set_drv(1'b1, 1'b1, PROBE);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_i_bus_released", i_dataM, PROBE);
        check("reset_d_bus_released", d_dataM, PROBE);
        reset_n = 1'b1;
        set_drv(1'b0, 1'b0, 64'h0);
        set_drv(1'b1, 1'b0, 64'h0);

        for (int k = 0; k < 9; k++) begin
            if (vecs[k].is_wr) do_write(vecs[k].port, vecs[k].addr, vecs[k].data, 1'b0);
            else               do_read(vecs[k].port, vecs[k].addr, vecs[k].data);
        end

        // Write accepted straight out of RDONE releases the bus on the next cycle.
        do_read(1'b1, 16'h0008, V2);
        do_write(1'b1, 16'h0030, VB, 1'b0);
        do_read(1'b1, 16'h0030, VB);

        // D commit to block 7 lands on the I-port load edge: I sees pre-write data.
        fork
            do_write(1'b1, 16'h001C, N7, 1'b0);
            begin
                tick();
                do_read(1'b0, 16'h001C, V7);
            end
        join
        do_read(1'b0, 16'h001C, N7);

        // Both ports commit block 9 on the same edge.
        fork
            do_write(1'b0, 16'h0024, I9, 1'b0);
            do_write(1'b1, 16'h0024, D9, 1'b0);
        join
        do_read(1'b0, 16'h0024, D9);

        // Read plus write together is a write; address wraps to block 255.
        do_write(1'b1, 16'hFFFC, VF, 1'b1);
        do_read(1'b0, 16'h03FC, VF);

        // Reset while in RDONE releases the bus without waiting for an edge.
        do_read(1'b1, 16'h0014, V5);
        @(posedge clk); #2;
        reset_n = 1'b0;
        set_drv(1'b1, 1'b1, PROBE);
        #1 check("rst_rdone_released", d_dataM, PROBE);
        @(negedge clk); reset_n = 1'b1;

        // Reset mid-read (cnt=2) aborts it: no data ever appears.
        set_req(1'b1, 1'b1, 1'b0, 16'h0008);
        tick();
        set_req(1'b1, 1'b0, 1'b0, 16'h0);
        tick();
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        repeat (3) tick();
        @(negedge clk); check("rst_read_aborted", d_dataM, PROBE);
        do_read(1'b1, 16'h0008, V2);

        // Reset mid-write (cnt=3) discards it: block 5 keeps its old contents.
        set_req(1'b1, 1'b0, 1'b1, 16'h0014);
        tick();
        set_drv(1'b1, 1'b1, PROBE);
        tick();
        tick();
        set_req(1'b1, 1'b0, 1'b0, 16'h0);
        set_drv(1'b1, 1'b1, BAD);
        #2 reset_n = 1'b0;
        #1 check("rst_wbusy_released", d_dataM, BAD);
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        set_drv(1'b1, 1'b0, 64'h0);
        do_read(1'b1, 16'h0014, V5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
